// File: rtl/iic_pkg.sv
// Shared encodings for the I2C transaction sequencer and its command issuer.
package iic_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned DEV_W  = 7;

  // Top-level transaction phases.
  typedef enum logic [3:0] {
    S_IDLE,
    S_A_W,
    S_R_ADR,
    S_WD,
    S_P1,
    S_A_R,
    S_RD,
    S_P2,
    S_FIN
  } seq_state_t;

  // Per-command phases of the issuer; IS_IDLE waits for the next go.
  typedef enum logic [1:0] {
    IS_IDLE,
    IS_ISSUE,
    IS_GUARD,
    IS_WAIT
  } iss_state_t;

  localparam logic IIC_RW_WRITE = 1'b0;
  localparam logic IIC_RW_READ  = 1'b1;

endpackage

// File: rtl/iic_cmd_issuer.sv
// Issues one engine command (start+byte or stop), then waits for the engine
// to go idle with a bounded wait.
// Ports: go/is_stop/rw/din  command request (go is a 1-cycle pulse, idle only)
//        core_*             engine strobes and byte, core_busy/core_dout back
//        done               1-cycle pulse, command finished
//        timeout            1-cycle pulse, engine stayed busy too long
//        rx_byte            byte captured at the end of a read command
module iic_cmd_issuer
  import iic_pkg::*;
#(
  parameter int unsigned TIMEOUT = 4096
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        go,
  input  logic        is_stop,
  input  logic        rw,
  input  logic [7:0]  din,
  input  logic        core_busy,
  input  logic [7:0]  core_dout,
  output logic        core_start,
  output logic        core_stop,
  output logic        core_rw,
  output logic [7:0]  core_din,
  output logic        done,
  output logic        timeout,
  output logic [7:0]  rx_byte
);

  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);

  iss_state_t       state;
  logic [CNT_W-1:0] wait_cnt;

  // ISSUE strobes for one cycle, GUARD skips the engine's stale busy,
  // WAIT completes on the first idle cycle or aborts at the timeout.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state      <= IS_IDLE;
      wait_cnt   <= '0;
      core_start <= 1'b0;
      core_stop  <= 1'b0;
      core_rw    <= 1'b0;
      core_din   <= '0;
      done       <= 1'b0;
      timeout    <= 1'b0;
      rx_byte    <= '0;
    end else begin
      done    <= 1'b0;
      timeout <= 1'b0;
      case (state)
        IS_IDLE: begin
          if (go) begin
            core_start <= ~is_stop;
            core_stop  <= is_stop;
            core_rw    <= rw;
            core_din   <= din;
            state      <= IS_ISSUE;
          end
        end
        IS_ISSUE: begin
          core_start <= 1'b0;
          core_stop  <= 1'b0;
          state      <= IS_GUARD;
        end
        IS_GUARD: begin
          wait_cnt <= '0;
          state    <= IS_WAIT;
        end
        IS_WAIT: begin
          if (!core_busy) begin
            done  <= 1'b1;
            state <= IS_IDLE;
            if (core_rw == IIC_RW_READ) rx_byte <= core_dout;
          end else if (wait_cnt == CNT_MAX) begin
            timeout <= 1'b1;
            state   <= IS_IDLE;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        default: state <= IS_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/iic_seq.sv
// Register-style I2C transaction sequencer in front of the byte engine.
// Write: S,dev+W,reg,data*N,P.  Read: S,dev+W,reg,P then S,dev+R,data*N,P.
// Ports: req_*            request handshake (dev, reg, len, rw)
//        wr_*             write-data stream in, rd_* read-data stream out
//        done / err       1-cycle completion / timeout-abort pulses
//        core_*           engine command strobes, byte out, byte in, busy
module iic_seq
  import iic_pkg::*;
#(
  parameter int unsigned LEN_W   = 4,
  parameter int unsigned TIMEOUT = 4096
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_rw,
  input  logic [6:0]       req_dev,
  input  logic [7:0]       req_reg,
  input  logic [LEN_W-1:0] req_len,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [7:0]       wr_data,
  output logic             rd_valid,
  input  logic             rd_ready,
  output logic [7:0]       rd_data,
  output logic             done,
  output logic             err,
  output logic             core_start,
  output logic             core_stop,
  output logic             core_rw,
  output logic [7:0]       core_din,
  input  logic [7:0]       core_dout,
  input  logic             core_busy
);

  seq_state_t        state;
  logic              issued;
  logic [LEN_W-1:0]  cnt;
  logic              lat_rw;
  logic [DEV_W-1:0]  lat_dev;
  logic [BYTE_W-1:0] lat_reg;

  logic              iss_go;
  logic              iss_stop;
  logic              iss_rw;
  logic [BYTE_W-1:0] iss_din;
  logic              iss_done;
  logic [BYTE_W-1:0] iss_byte;

  logic              cmd_stop_c;
  logic              cmd_rw_c;
  logic [BYTE_W-1:0] cmd_din_c;
  seq_state_t        next_c;

  // err comes straight from the issuer's registered timeout pulse.
  iic_cmd_issuer #(.TIMEOUT(TIMEOUT)) u_issuer (
    .clock      (clock),
    .reset_n    (reset_n),
    .go         (iss_go),
    .is_stop    (iss_stop),
    .rw         (iss_rw),
    .din        (iss_din),
    .core_busy  (core_busy),
    .core_dout  (core_dout),
    .core_start (core_start),
    .core_stop  (core_stop),
    .core_rw    (core_rw),
    .core_din   (core_din),
    .done       (iss_done),
    .timeout    (err),
    .rx_byte    (iss_byte)
  );

  // Command fields and follow-on phase for the current state.
  always_comb begin
    cmd_stop_c = 1'b0;
    cmd_rw_c   = IIC_RW_WRITE;
    cmd_din_c  = '0;
    next_c     = S_IDLE;
    case (state)
      S_A_W: begin
        cmd_din_c = {lat_dev, IIC_RW_WRITE};
        next_c    = S_R_ADR;
      end
      S_R_ADR: begin
        cmd_din_c = lat_reg;
        next_c    = (lat_rw == IIC_RW_READ || cnt == '0) ? S_P1 : S_WD;
      end
      S_WD: cmd_din_c = wr_data;
      S_P1: begin
        cmd_stop_c = 1'b1;
        next_c     = (lat_rw == IIC_RW_READ && cnt != '0) ? S_A_R : S_FIN;
      end
      S_A_R: begin
        cmd_din_c = {lat_dev, IIC_RW_READ};
        next_c    = S_RD;
      end
      S_RD: cmd_rw_c = IIC_RW_READ;
      S_P2: begin
        cmd_stop_c = 1'b1;
        next_c     = S_FIN;
      end
      default: next_c = S_IDLE;
    endcase
  end

  // Top sequencer; `issued` marks a command in flight with the issuer.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      issued    <= 1'b0;
      cnt       <= '0;
      lat_rw    <= 1'b0;
      lat_dev   <= '0;
      lat_reg   <= '0;
      iss_go    <= 1'b0;
      iss_stop  <= 1'b0;
      iss_rw    <= 1'b0;
      iss_din   <= '0;
      req_ready <= 1'b1;
      wr_ready  <= 1'b0;
      rd_valid  <= 1'b0;
      rd_data   <= '0;
      done      <= 1'b0;
    end else begin
      iss_go <= 1'b0;
      done   <= 1'b0;
      if (err) begin
        // Timeout abort: back to idle, no stop issued.
        state     <= S_IDLE;
        issued    <= 1'b0;
        cnt       <= '0;
        wr_ready  <= 1'b0;
        rd_valid  <= 1'b0;
        req_ready <= 1'b1;
      end else begin
        case (state)
          S_IDLE: begin
            if (req_valid) begin
              lat_rw    <= req_rw;
              lat_dev   <= req_dev;
              lat_reg   <= req_reg;
              cnt       <= req_len;
              req_ready <= 1'b0;
              state     <= S_A_W;
            end
          end
          S_A_W, S_R_ADR, S_P1, S_A_R, S_P2: begin
            if (!issued) begin
              iss_go   <= 1'b1;
              iss_stop <= cmd_stop_c;
              iss_rw   <= cmd_rw_c;
              iss_din  <= cmd_din_c;
              issued   <= 1'b1;
            end else if (iss_done) begin
              issued <= 1'b0;
              state  <= next_c;
              if (next_c == S_FIN) done <= 1'b1;
            end
          end
          S_WD: begin
            // Engine is parked between bytes, so no timeout while waiting here.
            if (!issued) begin
              if (wr_ready && wr_valid) begin
                wr_ready <= 1'b0;
                iss_go   <= 1'b1;
                iss_stop <= cmd_stop_c;
                iss_rw   <= cmd_rw_c;
                iss_din  <= cmd_din_c;
                issued   <= 1'b1;
              end else begin
                wr_ready <= 1'b1;
              end
            end else if (iss_done) begin
              issued <= 1'b0;
              cnt    <= cnt - LEN_W'(1);
              state  <= (cnt == LEN_W'(1)) ? S_P1 : S_WD;
            end
          end
          S_RD: begin
            // Next byte is not requested until the current one is taken.
            if (rd_valid) begin
              if (rd_ready) begin
                rd_valid <= 1'b0;
                state    <= (cnt == '0) ? S_P2 : S_RD;
              end
            end else if (!issued) begin
              iss_go   <= 1'b1;
              iss_stop <= cmd_stop_c;
              iss_rw   <= cmd_rw_c;
              iss_din  <= cmd_din_c;
              issued   <= 1'b1;
            end else if (iss_done) begin
              issued   <= 1'b0;
              rd_data  <= iss_byte;
              rd_valid <= 1'b1;
              cnt      <= cnt - LEN_W'(1);
            end
          end
          S_FIN: begin
            req_ready <= 1'b1;
            state     <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_iic_seq.sv
// Scoreboard bench for iic_seq with a behavioural byte-engine model.
module tb_iic_seq;

  localparam int LEN_W   = 4;
  localparam int TIMEOUT = 64;

  logic             clock = 1'b0;
  logic             reset_n;
  logic             req_valid;
  logic             req_ready;
  logic             req_rw;
  logic [6:0]       req_dev;
  logic [7:0]       req_reg;
  logic [LEN_W-1:0] req_len;
  logic             wr_valid;
  logic             wr_ready;
  logic [7:0]       wr_data;
  logic             rd_valid;
  logic             rd_ready;
  logic [7:0]       rd_data;
  logic             done;
  logic             err;
  logic             core_start;
  logic             core_stop;
  logic             core_rw;
  logic [7:0]       core_din;
  logic [7:0]       core_dout;
  logic             core_busy;

  iic_seq #(.LEN_W(LEN_W), .TIMEOUT(TIMEOUT)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_rw     (req_rw),
    .req_dev    (req_dev),
    .req_reg    (req_reg),
    .req_len    (req_len),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_data    (wr_data),
    .rd_valid   (rd_valid),
    .rd_ready   (rd_ready),
    .rd_data    (rd_data),
    .done       (done),
    .err        (err),
    .core_start (core_start),
    .core_stop  (core_stop),
    .core_rw    (core_rw),
    .core_din   (core_din),
    .core_dout  (core_dout),
    .core_busy  (core_busy)
  );

  always #5 clock = ~clock;

  // Engine model: busy one cycle after a strobe, high 18 cycles; hang keeps it high.
  logic hang = 1'b0;
  int   eng_cnt;
  assign core_dout = 8'hA5;
  always @(posedge clock) begin
    if (!reset_n) begin
      core_busy <= 1'b0;
      eng_cnt   <= 0;
    end else if (core_start || core_stop) begin
      core_busy <= 1'b1;
      eng_cnt   <= 17;
    end else if (core_busy && !hang) begin
      if (eng_cnt == 0) core_busy <= 1'b0;
      else eng_cnt <= eng_cnt - 1;
    end
  end

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // Expected command entry: {care_din, stop, rw, din}.
  logic [10:0] exp_cmd[$];
  logic [7:0]  exp_rd[$];
  logic        exp_evt[$];   // 0 = done, 1 = err
  int          last_strobe_cyc = 0;
  logic        wr_seen = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_cmd(input logic care, input logic stop, input logic rw, input logic [7:0] din);
    exp_cmd.push_back({care, stop, rw, din});
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents something.
  always @(negedge clock) begin
    logic [10:0] e;
    logic [7:0]  r;
    logic        ev;
    if (reset_n) begin
      if (wr_ready) wr_seen = 1'b1;
      if (core_start || core_stop) begin
        last_strobe_cyc = cyc;
        chk("start_stop_exclusive", {31'd0, core_start & core_stop}, 32'd0);
        if (exp_cmd.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_cmd: start=%0b stop=%0b din=%0h", core_start, core_stop, core_din);
        end else begin
          e = exp_cmd.pop_front();
          chk("cmd_stop", {31'd0, core_stop}, {31'd0, e[9]});
          if (!e[9]) chk("cmd_rw", {31'd0, core_rw}, {31'd0, e[8]});
          if (e[10]) chk("cmd_din", {24'd0, core_din}, {24'd0, e[7:0]});
        end
      end
      if (rd_valid && rd_ready) begin
        if (exp_rd.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_rd: data=%0h", rd_data);
        end else begin
          r = exp_rd.pop_front();
          chk("rd_data", {24'd0, rd_data}, {24'd0, r});
        end
      end
      if (done || err) begin
        if (exp_evt.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_evt: done=%0b err=%0b", done, err);
        end else begin
          ev = exp_evt.pop_front();
          chk("evt_is_err", {31'd0, err}, {31'd0, ev});
          chk("evt_exclusive", {31'd0, done & err}, 32'd0);
          if (err) chk("err_latency", 32'(cyc - last_strobe_cyc), 32'd66);
        end
      end
    end
  end

  task automatic send_req(input logic rw, input logic [6:0] dev, input logic [7:0] rg,
                          input logic [LEN_W-1:0] len);
    int i;
    for (i = 0; i < 200; i++) begin
      @(negedge clock);
      if (req_ready) break;
    end
    chk("req_ready_wait", {31'd0, req_ready}, 32'd1);
    req_rw    = rw;
    req_dev   = dev;
    req_reg   = rg;
    req_len   = len;
    req_valid = 1'b1;
    @(posedge clock);
    #1 req_valid = 1'b0;
  endtask

  task automatic feed_wr(input logic [7:0] b);
    int i;
    for (i = 0; i < 2000; i++) begin
      @(negedge clock);
      if (wr_ready) break;
    end
    chk("wr_ready_wait", {31'd0, wr_ready}, 32'd1);
    wr_data  = b;
    wr_valid = 1'b1;
    @(posedge clock);
    #1 wr_valid = 1'b0;
    wr_data = 8'h00;
  endtask

  task automatic wait_end();
    int i;
    for (i = 0; i < 3000; i++) begin
      @(negedge clock);
      if (done || err) break;
    end
    chk("end_seen", {31'd0, done | err}, 32'd1);
    chk("req_ready_at_end", {31'd0, req_ready}, 32'd0);
    @(negedge clock);
    chk("req_ready_after_end", {31'd0, req_ready}, 32'd1);
    chk("cmd_queue_empty", exp_cmd.size(), 32'd0);
    chk("rd_queue_empty", exp_rd.size(), 32'd0);
    chk("evt_queue_empty", exp_evt.size(), 32'd0);
  endtask

  task automatic check_reset_outputs();
    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_wr_ready", {31'd0, wr_ready}, 32'd0);
    chk("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
    chk("rst_rd_data", {24'd0, rd_data}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_core_strobes", {30'd0, core_start, core_stop}, 32'd0);
    chk("rst_core_rw", {31'd0, core_rw}, 32'd0);
    chk("rst_core_din", {24'd0, core_din}, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n   = 1'b0;
    req_valid = 1'b0;
    req_rw    = 1'b0;
    req_dev   = '0;
    req_reg   = '0;
    req_len   = '0;
    wr_valid  = 1'b0;
    wr_data   = '0;
    rd_ready  = 1'b1;
    repeat (3) @(posedge clock);
    #1 reset_n = 1'b1;
    @(negedge clock);
    check_reset_outputs();

    // Write len=2.
    push_cmd(1, 0, 0, 8'hA0);
    push_cmd(1, 0, 0, 8'h10);
    push_cmd(1, 0, 0, 8'h11);
    push_cmd(1, 0, 0, 8'h22);
    push_cmd(0, 1, 0, 8'h00);
    exp_evt.push_back(1'b0);
    send_req(1'b0, 7'h50, 8'h10, 4'd2);
    feed_wr(8'h11);
    feed_wr(8'h22);
    wait_end();

    // Read len=3, consumer always ready.
    rd_ready = 1'b1;
    push_cmd(1, 0, 0, 8'hA0);
    push_cmd(1, 0, 0, 8'h03);
    push_cmd(0, 1, 0, 8'h00);
    push_cmd(1, 0, 0, 8'hA1);
    for (int i = 0; i < 3; i++) begin
      push_cmd(0, 0, 1, 8'h00);
      exp_rd.push_back(8'hA5);
    end
    push_cmd(0, 1, 0, 8'h00);
    exp_evt.push_back(1'b0);
    send_req(1'b1, 7'h50, 8'h03, 4'd3);
    wait_end();

    // Read len=2 with back-pressure on the first beat.
    rd_ready = 1'b0;
    push_cmd(1, 0, 0, 8'hA0);
    push_cmd(1, 0, 0, 8'h07);
    push_cmd(0, 1, 0, 8'h00);
    push_cmd(1, 0, 0, 8'hA1);
    for (int i = 0; i < 2; i++) begin
      push_cmd(0, 0, 1, 8'h00);
      exp_rd.push_back(8'hA5);
    end
    push_cmd(0, 1, 0, 8'h00);
    exp_evt.push_back(1'b0);
    send_req(1'b1, 7'h50, 8'h07, 4'd2);
    for (int i = 0; i < 2000; i++) begin
      @(negedge clock);
      if (rd_valid) break;
    end
    chk("rd_valid_seen", {31'd0, rd_valid}, 32'd1);
    for (int i = 0; i < 10; i++) begin
      if (i > 0) @(negedge clock);
      chk("hold_rd_valid", {31'd0, rd_valid}, 32'd1);
      chk("hold_rd_data", {24'd0, rd_data}, 32'h0000_00A5);
      chk("hold_no_start", {31'd0, core_start}, 32'd0);
    end
    @(posedge clock);
    #1 rd_ready = 1'b1;
    wait_end();

    // len=0 write: address phase only, no write-data request.
    wr_seen = 1'b0;
    push_cmd(1, 0, 0, 8'hA0);
    push_cmd(1, 0, 0, 8'h03);
    push_cmd(0, 1, 0, 8'h00);
    exp_evt.push_back(1'b0);
    send_req(1'b0, 7'h50, 8'h03, 4'd0);
    wait_end();
    chk("len0_no_wr_ready", {31'd0, wr_seen}, 32'd0);

    // Engine hangs after the first start: timeout abort, no stop.
    hang = 1'b1;
    push_cmd(1, 0, 0, 8'hA0);
    exp_evt.push_back(1'b1);
    send_req(1'b0, 7'h50, 8'h10, 4'd1);
    wait_end();
    repeat (30) @(negedge clock);
    chk("timeout_no_late_cmd", exp_cmd.size(), 32'd0);
    reset_n = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
    hang = 1'b0;

    // Reset while waiting for write data, then a fresh request.
    push_cmd(1, 0, 0, 8'hA0);
    push_cmd(1, 0, 0, 8'h10);
    send_req(1'b0, 7'h50, 8'h10, 4'd2);
    for (int i = 0; i < 2000; i++) begin
      @(negedge clock);
      if (wr_ready) break;
    end
    chk("wd_reached", {31'd0, wr_ready}, 32'd1);
    reset_n = 1'b0;
    @(posedge clock);
    #1 reset_n = 1'b1;
    @(negedge clock);
    check_reset_outputs();
    chk("wd_cmds_consumed", exp_cmd.size(), 32'd0);
    exp_cmd.delete();
    push_cmd(1, 0, 0, 8'h78);
    push_cmd(1, 0, 0, 8'h44);
    push_cmd(1, 0, 0, 8'h5C);
    push_cmd(0, 1, 0, 8'h00);
    exp_evt.push_back(1'b0);
    send_req(1'b0, 7'h3C, 8'h44, 4'd1);
    feed_wr(8'h5C);
    wait_end();

    repeat (5) @(negedge clock);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
